// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM state encoding
// and the iteration-counter width helper.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_NEG  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHRA = 4'd8;
  localparam logic [3:0] OP_ROR  = 4'd9;
  localparam logic [3:0] OP_ROL  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_DIV  = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter must hold the value WIDTH itself, hence WIDTH+1.
  function automatic int cnt_bits(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative unsigned MUL (shift-add) / DIV (restoring) datapath.
// next_hi/next_lo are the accumulator values after one more step.
module alu_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] next_lo,
  output logic [WIDTH-1:0] next_hi
);

  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;
  logic             div_mode;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;

  // MUL: acc_lo holds the multiplier and shifts out one bit per step while the
  // product grows into acc_hi. DIV: acc_lo holds the dividend, quotient bits
  // shift in at the bottom, acc_hi is the running remainder.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd};
    div_diff  = div_shift[WIDTH-1:0] - opnd;
    if (div_mode) begin
      next_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      next_lo = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      next_hi = mul_sum[WIDTH:1];
      next_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      div_mode <= 1'b0;
    end else if (load) begin
      div_mode <= is_div;
      acc_hi   <= '0;
      acc_lo   <= is_div ? op_a : op_b;
      opnd     <= is_div ? op_b : op_a;
    end else if (step) begin
      acc_hi <= next_hi;
      acc_lo <= next_lo;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus iterative MUL/DIV,
// with registered HI/LO results. WIDTH must be a power of two, at least 4.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int CW = cnt_bits(WIDTH);
  localparam int SW = $clog2(WIDTH);

  // Handshake: start/opcode/operands are taken only on an edge where the
  // block is IDLE and start is high; done is a one-cycle pulse, results valid.
  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic             iter_op;
  logic             accept;
  logic             dz_pending;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] single_lo;
  logic [WIDTH-1:0] iter_lo;
  logic [WIDTH-1:0] iter_hi;

  assign iter_op = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign accept  = (state == ST_IDLE) && start;
  assign shamt   = input_b[SW-1:0];
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);

  always_comb begin
    single_lo = '0;
    case (opcode)
      OP_AND:  single_lo = input_a & input_b;
      OP_OR:   single_lo = input_a | input_b;
      OP_NOT:  single_lo = ~input_a;
      OP_NEG:  single_lo = '0 - input_a;
      OP_ADD:  single_lo = input_a + input_b;
      OP_SUB:  single_lo = input_a - input_b;
      OP_SHR:  single_lo = input_a >> shamt;
      OP_SHL:  single_lo = input_a << shamt;
      OP_SHRA: single_lo = $signed(input_a) >>> shamt;
      OP_ROR:  single_lo = WIDTH'({input_a, input_a} >> shamt);
      OP_ROL:  single_lo = WIDTH'(({input_a, input_a} << shamt) >> WIDTH);
      default: single_lo = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = iter_op ? ST_RUN : ST_DONE;
      ST_RUN:  if (cnt == CW'(1)) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clock   (clock),
    .clear   (clear),
    .load    (accept && iter_op),
    .step    (state == ST_RUN),
    .is_div  (opcode == OP_DIV),
    .op_a    (input_a),
    .op_b    (input_b),
    .next_lo (iter_lo),
    .next_hi (iter_hi)
  );

  // Iterative results are captured from the final step directly, so the
  // output registers never show a partial product or remainder.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      dz_pending  <= 1'b0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        if (iter_op) begin
          cnt        <= CW'(WIDTH);
          dz_pending <= (opcode == OP_DIV) && (input_b == '0);
        end else begin
          result_lo   <= single_lo;
          result_hi   <= '0;
          div_by_zero <= 1'b0;
        end
      end else if (state == ST_RUN) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          result_lo   <= iter_lo;
          result_hi   <= iter_hi;
          div_by_zero <= dz_pending;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=8: directed vector table,
// handshake/reset corner sequences and randomized ops against a reference model.
module tb_alu_seq;

  localparam int W = 8;

  logic         clock;
  logic         clear;
  logic         start;
  logic [3:0]   opcode;
  logic [W-1:0] input_a;
  logic [W-1:0] input_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result_lo;
  logic [W-1:0] result_hi;
  logic         div_by_zero;

  int n_checks = 0;
  int n_pass   = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .opcode      (opcode),
    .input_a     (input_a),
    .input_b     (input_b),
    .busy        (busy),
    .done        (done),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .div_by_zero (div_by_zero)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       dz;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  // Reference model straight from the operation definitions, plain integers.
  task automatic model(input int op, input int a, input int b,
                       output int lo, output int hi, output int dz, output int lat);
    int s;
    int sa;
    int p;
    s = b % W;
    lo = 0; hi = 0; dz = 0; lat = 1;
    case (op)
      0:  lo = a & b;
      1:  lo = a | b;
      2:  lo = (~a) & 255;
      3:  lo = (256 - a) % 256;
      4:  lo = (a + b) % 256;
      5:  lo = (a - b + 256) % 256;
      6:  lo = a >> s;
      7:  lo = (a << s) % 256;
      8:  begin
            sa = (a >= 128) ? a - 256 : a;
            lo = (sa >>> s) & 255;
          end
      9:  lo = ((a >> s) | (a << (W - s))) & 255;
      10: lo = ((a << s) | (a >> (W - s))) & 255;
      11: begin
            p = a * b;
            lo = p % 256; hi = p / 256; lat = W + 1;
          end
      12: begin
            lat = W + 1;
            if (b == 0) begin lo = 255; hi = a; dz = 1; end
            else begin lo = a / b; hi = a % b; end
          end
      default: lo = 0;
    endcase
  endtask

  // ---------------- driver ----------------
  // Called ~1ns into an IDLE cycle; returns ~1ns into the following IDLE cycle.
  task automatic run_op(input string name, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] elo, input logic [7:0] ehi,
                        input logic edz, input int elat);
    int lat;
    logic busy_ok;
    start = 1'b1; opcode = op; input_a = a; input_b = b;
    tick();
    start = 1'b0;
    opcode = 4'($urandom_range(0, 15));
    input_a = 8'($urandom);
    input_b = 8'($urandom);
    lat = 1;
    busy_ok = busy;
    while (!done && lat < 30) begin
      tick();
      lat++;
      busy_ok = busy_ok & busy;
    end
    check({name, " latency"}, lat, elat);
    check({name, " busy"}, {31'd0, busy_ok}, 32'd1);
    check({name, " lo"}, {24'd0, result_lo}, {24'd0, elo});
    check({name, " hi"}, {24'd0, result_hi}, {24'd0, ehi});
    check({name, " dz"}, {31'd0, div_by_zero}, {31'd0, edz});
    tick();
    check({name, " idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  // ---------------- test body ----------------
  initial begin
    int mlo, mhi, mdz, mlat;
    int pulses;
    int done_cyc;
    logic [3:0] rop;
    logic [7:0] ra, rb;

    clear = 1'b1; start = 1'b0; opcode = '0; input_a = '0; input_b = '0;
    tick();
    tick();
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst lo", {24'd0, result_lo}, 32'd0);
    check("rst hi", {24'd0, result_hi}, 32'd0);
    check("rst dz", {31'd0, div_by_zero}, 32'd0);
    clear = 1'b0;
    tick();

    vecs.push_back('{"and",   4'd0,  8'd15,   8'd3,   8'h03, 8'h00, 1'b0, 1});
    vecs.push_back('{"or",    4'd1,  8'd15,   8'd3,   8'h0F, 8'h00, 1'b0, 1});
    vecs.push_back('{"not",   4'd2,  8'd15,   8'd3,   8'hF0, 8'h00, 1'b0, 1});
    vecs.push_back('{"neg",   4'd3,  8'd15,   8'd3,   8'hF1, 8'h00, 1'b0, 1});
    vecs.push_back('{"add",   4'd4,  8'd15,   8'd3,   8'h12, 8'h00, 1'b0, 1});
    vecs.push_back('{"sub",   4'd5,  8'd15,   8'd3,   8'h0C, 8'h00, 1'b0, 1});
    vecs.push_back('{"rol",   4'd10, 8'h81,   8'd1,   8'h03, 8'h00, 1'b0, 1});
    vecs.push_back('{"ror",   4'd9,  8'h81,   8'd1,   8'hC0, 8'h00, 1'b0, 1});
    vecs.push_back('{"shra",  4'd8,  8'h81,   8'd1,   8'hC0, 8'h00, 1'b0, 1});
    vecs.push_back('{"shr",   4'd6,  8'h81,   8'd1,   8'h40, 8'h00, 1'b0, 1});
    vecs.push_back('{"shl",   4'd7,  8'h81,   8'd1,   8'h02, 8'h00, 1'b0, 1});
    vecs.push_back('{"rol9",  4'd10, 8'h81,   8'd9,   8'h03, 8'h00, 1'b0, 1});
    vecs.push_back('{"mul",   4'd11, 8'd200,  8'd100, 8'h20, 8'h4E, 1'b0, 9});
    vecs.push_back('{"div",   4'd12, 8'd100,  8'd7,   8'd14, 8'd2,  1'b0, 9});
    vecs.push_back('{"div0",  4'd12, 8'd100,  8'd0,   8'hFF, 8'd100, 1'b1, 9});
    vecs.push_back('{"rsvd",  4'd13, 8'hAA,   8'h55,  8'h00, 8'h00, 1'b0, 1});
    vecs.push_back('{"sub_b", 4'd5,  8'd3,    8'd15,  8'hF4, 8'h00, 1'b0, 1});

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].lo, vecs[i].hi, vecs[i].dz, vecs[i].lat);

    // start re-pulsed during RUN (cycle 3) and DONE (cycle 9) must be ignored
    start = 1'b1; opcode = 4'd11; input_a = 8'd3; input_b = 8'd5;
    tick();
    start = 1'b0;
    pulses = 0;
    done_cyc = 0;
    for (int c = 1; c <= 14; c++) begin
      if (done) begin pulses++; done_cyc = c; end
      if (c == 3 || c == 9) begin
        start = 1'b1; opcode = 4'd12; input_a = 8'd100; input_b = 8'd7;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check("hs pulses", pulses, 1);
    check("hs done cycle", done_cyc, 9);
    check("hs lo", {24'd0, result_lo}, 32'd15);
    check("hs hi", {24'd0, result_hi}, 32'd0);
    check("hs dz", {31'd0, div_by_zero}, 32'd0);

    // clear at cycle 4 of a long multiply
    start = 1'b1; opcode = 4'd11; input_a = 8'd255; input_b = 8'd255;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    clear = 1'b1;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort lo", {24'd0, result_lo}, 32'd0);
    check("abort hi", {24'd0, result_hi}, 32'd0);
    check("abort dz", {31'd0, div_by_zero}, 32'd0);
    tick();
    clear = 1'b0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) pulses++;
      tick();
    end
    check("abort no done", pulses, 0);
    run_op("post abort add", 4'd4, 8'd1, 8'd2, 8'd3, 8'd0, 1'b0, 1);

    // randomized ops vs reference model
    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      model(int'(rop), int'(ra), int'(rb), mlo, mhi, mdz, mlat);
      run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb,
             8'(mlo), 8'(mhi), mdz[0], mlat);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
